// File: rtl/seq_normalizer.sv
// Iterative normalizer: shifts an operand left (leading-zero count) or right
// (trailing-zero count) one bit per cycle until the edge bit is set.
module seq_normalizer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_mode,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_zero
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zero_q, zero_d;
    logic             mode_q, mode_d;
    logic             edge_bit;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            mode_q  <= mode_d;
        end
    end

    // Bit that terminates the search: MSB for left-normalize, LSB for right.
    assign edge_bit = mode_q ? work_q[0] : work_q[WIDTH-1];

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    work_d = i_data;
                    mode_d = i_mode;
                    cnt_d  = '0;
                    zero_d = 1'b0;
                    if (i_data == '0) begin
                        // A zero operand never finds an edge bit; report full width.
                        state_d = DONE;
                        cnt_d   = CNT_W'(WIDTH);
                        zero_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (edge_bit) begin
                    state_d = DONE;
                end else begin
                    work_d = mode_q ? (work_q >> 1) : (work_q << 1);
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign o_busy  = (state_q != IDLE);
    assign o_done  = (state_q == DONE);
    assign o_data  = work_q;
    assign o_count = cnt_q;
    assign o_zero  = zero_q;

endmodule

// File: tb/tb_seq_normalizer.sv
// Scoreboard bench for seq_normalizer: expectations queued at request time,
// popped and compared when o_done is observed.
module tb_seq_normalizer;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_start;
    logic [WIDTH-1:0] i_data;
    logic             i_mode;
    logic             o_busy, o_done, o_zero;
    logic [WIDTH-1:0] o_data;
    logic [CNT_W-1:0] o_count;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [CNT_W-1:0] count;
        logic             zero;
        int               lat;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    logic prev_done = 1'b0;

    seq_normalizer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_data(i_data),
        .i_mode(i_mode), .o_busy(o_busy), .o_done(o_done), .o_data(o_data),
        .o_count(o_count), .o_zero(o_zero)
    );

    always #5 i_clk = ~i_clk;

    // o_done must never be high on two consecutive cycles
    always @(negedge i_clk) begin
        if (o_done) begin
            tests++;
            if (prev_done) begin
                fails++;
                $display("FAIL done_twice: o_done high in consecutive cycles at %0t", $time);
            end
        end
        prev_done = o_done;
    end

    // Reference: search for the edge bit by scanning, independent of the shift loop.
    function automatic exp_t model(input logic [WIDTH-1:0] d, input logic m);
        exp_t e;
        int   k;
        if (d == '0) begin
            e.data = '0; e.count = CNT_W'(WIDTH); e.zero = 1'b1; e.lat = 0;
        end else begin
            k = 0;
            if (!m) begin
                while (!d[WIDTH-1-k]) k++;
                e.data = d << k;
            end else begin
                while (!d[k]) k++;
                e.data = d >> k;
            end
            e.count = CNT_W'(k); e.zero = 1'b0; e.lat = k + 1;
        end
        return e;
    endfunction

    // Called in IDLE away from an edge. disturb: cycle index at which a stray
    // i_start pulse with a different operand is driven (-1 = none).
    task automatic run_op(input logic [WIDTH-1:0] d, input logic m, input int disturb);
        exp_t e;
        int   cyc;
        bit   seen;
        sb.push_back(model(d, m));
        i_start = 1'b1; i_data = d; i_mode = m;
        @(posedge i_clk); #1;
        i_start = 1'b0; i_data = ~d; i_mode = ~m;
        cyc = 0; seen = 0;
        while (!seen && cyc < 100) begin
            @(negedge i_clk);
            if (cyc == disturb) begin
                i_start = 1'b1; i_data = 32'h0000_0001; i_mode = 1'b0;
            end else begin
                i_start = 1'b0;
            end
            tests++;
            if (o_busy !== 1'b1) begin
                fails++;
                $display("FAIL busy_run: o_busy=%b required 1 at cycle %0d (d=%h)", o_busy, cyc, d);
            end
            if (o_done === 1'b1) seen = 1;
            else begin
                @(posedge i_clk);
                cyc++;
            end
        end
        i_start = 1'b0;
        e = sb.pop_front();
        tests++;
        if (!seen || cyc !== e.lat) begin
            fails++;
            $display("FAIL latency: done after E%0d (seen=%0d) required E%0d (d=%h m=%b)", cyc, seen, e.lat, d, m);
        end
        tests++;
        if (o_data !== e.data || o_count !== e.count || o_zero !== e.zero) begin
            fails++;
            $display("FAIL result: data=%h count=%0d zero=%b required data=%h count=%0d zero=%b (d=%h m=%b)",
                     o_data, o_count, o_zero, e.data, e.count, e.zero, d, m);
        end
        @(posedge i_clk); #1;
        tests++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_data !== e.data || o_count !== e.count || o_zero !== e.zero) begin
            fails++;
            $display("FAIL hold_idle: busy=%b done=%b data=%h count=%0d zero=%b required 0 0 %h %0d %b",
                     o_busy, o_done, o_data, o_count, o_zero, e.data, e.count, e.zero);
        end
    endtask

    task automatic test_reset;
        i_rst = 1'b1; i_start = 1'b0; i_data = '0; i_mode = 1'b0;
        #1;
        tests++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_data !== '0 || o_count !== '0 || o_zero !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: busy=%b done=%b data=%h count=%0d zero=%b required all 0",
                     o_busy, o_done, o_data, o_count, o_zero);
        end
        // i_start while reset is high must not be taken
        i_start = 1'b1; i_data = 32'h0000_0010;
        @(posedge i_clk); #1;
        tests++;
        if (o_busy !== 1'b0) begin
            fails++;
            $display("FAIL start_in_reset: o_busy=%b required 0", o_busy);
        end
        i_rst = 1'b0; i_start = 1'b0;
        @(posedge i_clk); #1;
    endtask

    task automatic test_left;
        run_op(32'h0000_0001, 1'b0, -1);
        run_op(32'h8000_0000, 1'b0, -1);
        run_op(32'h0001_2345, 1'b0, -1);
    endtask

    task automatic test_right;
        run_op(32'h0000_0100, 1'b1, -1);
        run_op(32'h8000_0000, 1'b1, -1);
        run_op(32'h0000_0001, 1'b1, -1);
    endtask

    task automatic test_zero;
        run_op(32'h0000_0000, 1'b0, -1);
        run_op(32'h0000_0000, 1'b1, -1);
    endtask

    task automatic test_ignore_start;
        run_op(32'h0000_00F0, 1'b0, 5);
    endtask

    task automatic test_reset_mid_run;
        int edges;
        i_start = 1'b1; i_data = 32'h0000_0001; i_mode = 1'b0;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        for (int i = 1; i < 10; i++) @(posedge i_clk);
        #2;
        i_rst = 1'b1;
        #1;
        tests++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_data !== '0 || o_count !== '0 || o_zero !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_run: busy=%b done=%b data=%h count=%0d zero=%b required all 0",
                     o_busy, o_done, o_data, o_count, o_zero);
        end
        edges = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            if (o_done) edges++;
        end
        tests++;
        if (edges != 0) begin
            fails++;
            $display("FAIL reset_no_done: %0d done cycles during reset required 0", edges);
        end
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        run_op(32'h4000_0000, 1'b0, -1);
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   cyc;
        bit   seen;
        sb.push_back(model(32'h0000_8000, 1'b0));
        sb.push_back(model(32'h0000_0004, 1'b1));
        i_start = 1'b1; i_data = 32'h0000_8000; i_mode = 1'b0;
        @(posedge i_clk); #1;
        cyc = 0; seen = 0;
        while (!seen && cyc < 100) begin
            @(negedge i_clk);
            if (o_done === 1'b1) seen = 1;
            else begin @(posedge i_clk); cyc++; end
        end
        e = sb.pop_front();
        tests++;
        if (!seen || cyc !== e.lat || o_data !== e.data || o_count !== e.count) begin
            fails++;
            $display("FAIL b2b_first: lat=%0d data=%h count=%0d required lat=%0d data=%h count=%0d",
                     cyc, o_data, o_count, e.lat, e.data, e.count);
        end
        // keep i_start high; next op starts after one idle cycle
        i_data = 32'h0000_0004; i_mode = 1'b1;
        cyc = 0; seen = 0;
        while (!seen && cyc < 100) begin
            @(posedge i_clk); cyc++;
            @(negedge i_clk);
            if (o_done === 1'b1) seen = 1;
        end
        i_start = 1'b0;
        e = sb.pop_front();
        tests++;
        if (!seen || cyc !== e.lat + 2 || o_data !== e.data || o_count !== e.count) begin
            fails++;
            $display("FAIL b2b_second: edges=%0d data=%h count=%0d required edges=%0d data=%h count=%0d",
                     cyc, o_data, o_count, e.lat + 2, e.data, e.count);
        end
        @(posedge i_clk); #1;
    endtask

    task automatic test_random;
        logic [WIDTH-1:0] d;
        logic             m;
        int               sh;
        for (int i = 0; i < 16; i++) begin
            m  = 1'($urandom_range(0, 1));
            sh = $urandom_range(0, WIDTH - 1);
            if (i % 7 == 3) d = '0;
            else if (!m) d = ($urandom | 32'h8000_0000) >> sh;
            else d = ($urandom | 32'h0000_0001) << sh;
            run_op(d, m, (i % 3 == 0) ? 1 : -1);
        end
    endtask

    initial begin
        test_reset();
        test_left();
        test_right();
        test_zero();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_normalizer.md
SEQ_NORMALIZER -- requirements
Module: seq_normalizer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data path width in bits (power of two, >= 4).
REQ-002 SHALL have parameter CNT_W, default 6, count width; SHALL satisfy 2**CNT_W > WIDTH.
REQ-003 SHALL have port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port i_data  input  WIDTH  operand; captured on accepted i_start.
REQ-007 SHALL have port i_mode  input  1  0 = left-normalize (count leading zeros), 1 = right-normalize (count trailing zeros); captured with i_data.
REQ-008 SHALL have port o_busy  output  1  high in RUN and DONE.
REQ-009 SHALL have port o_done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port o_data  output  WIDTH  normalized result.
REQ-011 SHALL have port o_count  output  CNT_W  number of bit positions shifted.
REQ-012 SHALL have port o_zero  output  1  high when the captured operand was zero.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; o_done = (state == DONE), registered, no combinational path from inputs.
REQ-014 IDLE: i_start=1 at edge E0 SHALL load the working register with i_data, latch i_mode, clear count, and clear o_zero.
REQ-015 IDLE, i_data != 0 at E0: next state SHALL be RUN.
REQ-016 IDLE, i_data == 0 at E0: next state SHALL be DONE, with o_count = WIDTH, o_data = 0, o_zero = 1.
REQ-017 RUN, mode 0: if working MSB = 1, go to DONE; else shift working register left 1 (zero fill) and increment count.
REQ-018 RUN, mode 1: if working LSB = 1, go to DONE; else shift working register right 1 (logical, zero fill) and increment count.
REQ-019 Latency, nonzero operand with k shifts: o_done SHALL be high in the cycle following edge E(k+1); zero operand: in the cycle following E0.
REQ-020 DONE SHALL last exactly one cycle, then IDLE; o_done SHALL never be high for two consecutive cycles.
REQ-021 o_data, o_count, o_zero SHALL reflect the working registers at all times and SHALL be held stable from DONE until the next accepted i_start.
REQ-022 i_start asserted in RUN or DONE SHALL be ignored (not queued).
REQ-023 i_start held continuously SHALL start a new operation on the first IDLE edge after each DONE, i.e. one idle cycle between operations.
REQ-024 i_data and i_mode changes after E0 SHALL NOT affect an operation in progress.
REQ-025 Count SHALL never exceed WIDTH-1 for a nonzero operand; no wrap-around is possible.

Reset
REQ-026 i_rst=1 SHALL immediately force state IDLE, o_busy=0, o_done=0, o_data=0, o_count=0, o_zero=0, and latched mode=0, independent of i_clk.
REQ-027 Reset asserted mid-RUN SHALL abort the operation with no o_done pulse; after release, the block SHALL accept i_start on the first edge.
REQ-028 i_start coincident with reset release SHALL be accepted only if i_rst is low at that sampling edge.

Verification
REQ-029 mode0, i_data=32'h0000_0001 -> o_count=31, o_data=32'h8000_0000, o_zero=0; o_done in the cycle after E32; o_busy high from E0 through the DONE cycle.
REQ-030 mode0, i_data=32'h8000_0000 -> o_count=0, o_data=32'h8000_0000; o_done in the cycle after E1.
REQ-031 either mode, i_data=0 -> o_count=32, o_data=0, o_zero=1; o_done in the cycle after E0.
REQ-032 mode1, i_data=32'h0000_0100 -> o_count=8, o_data=32'h0000_0001; o_done in the cycle after E9.
REQ-033 start 32'h0000_00F0 mode0, then pulse i_start with a different operand during RUN -> second request ignored; result o_count=24, o_data=32'hF000_0000.
REQ-034 start 32'h0000_0001 mode0, assert i_rst at E10 -> all outputs 0, no o_done pulse; then start 32'h4000_0000 -> o_count=1, o_data=32'h8000_0000.
